// File: rtl/multiplier_unit.sv
// multiplier_unit: pipelined RV-style multiplier (MUL/MULH/MULHSU/MULHU).
// Stage 1 captures the extended operands, stage 2 forms the product and
// selects the result half, and the remaining stages carry the result to the
// output register (stage STAGES).
// Optional feature: define MULTIPLIER_STAGE_TAP_EN to drive stage_rd_addr and
// stage_rd_en from the live stage contents for hazard detection; otherwise
// both are tied to 0.
// Handshake: an operation is accepted on a rising edge with in_valid=1,
// stall=0 and flush=0. There is no backpressure other than stall, and
// out_valid is a one-cycle-per-result qualifier for ans/out_rd_*.
module multiplier_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [XLEN-1:0]       rs1_value,
  input  logic [XLEN-1:0]       rs2_value,
  input  logic [1:0]            funct,
  input  logic [4:0]            rd_addr,
  input  logic                  rd_en,
  output logic                  out_valid,
  output logic [4:0]            out_rd_addr,
  output logic                  out_rd_en,
  output logic [XLEN-1:0]       ans,
  output logic                  busy,
  output logic [5*STAGES-1:0]   stage_rd_addr,
  output logic [STAGES-1:0]     stage_rd_en
);

  localparam int LAST = STAGES - 1;

  // Per-stage control; index 0 is stage 1, index LAST is the output register.
  // en_q holds valid & rd_en so it can feed stage_rd_en directly.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] en_q, en_d;
  logic [4:0]        rd_q  [STAGES-1:0];
  logic [4:0]        rd_d  [STAGES-1:0];

  // Stage 1 operands (already extended to XLEN+1 bits) and operation.
  logic [XLEN:0]     a1_q, a1_d;
  logic [XLEN:0]     b1_q, b1_d;
  logic [1:0]        f1_q, f1_d;

  // Results for stages 2..STAGES.
  logic [XLEN-1:0]   res_q [LAST:1];
  logic [XLEN-1:0]   res_d [LAST:1];

  logic              accept;
  logic              rs1_signed;
  logic              rs2_signed;
  logic [XLEN:0]     a_ext;
  logic [XLEN:0]     b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   sel_res;

  assign accept = in_valid & ~stall & ~flush;

  // Operand extension: rs1 signed for MULH/MULHSU, rs2 signed for MULH only.
  assign rs1_signed = (funct == 2'b01) || (funct == 2'b10);
  assign rs2_signed = (funct == 2'b01);
  assign a_ext      = {rs1_signed & rs1_value[XLEN-1], rs1_value};
  assign b_ext      = {rs2_signed & rs2_value[XLEN-1], rs2_value};

  // Only the low 2*XLEN bits of the (2*XLEN+2)-bit signed product are ever
  // selected, so a modular multiply of sign-extended operands is exact there.
  assign prod    = {{(XLEN-1){a1_q[XLEN]}}, a1_q} * {{(XLEN-1){b1_q[XLEN]}}, b1_q};
  assign sel_res = (f1_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Next-state: flush clears everything, stall holds, otherwise shift by one.
  always_comb begin
    vld_d = vld_q;
    en_d  = en_q;
    rd_d  = rd_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    f1_d  = f1_q;
    res_d = res_q;
    if (flush) begin
      vld_d = '0;
      en_d  = '0;
      a1_d  = '0;
      b1_d  = '0;
      f1_d  = '0;
      for (int k = 0; k < STAGES; k++) rd_d[k] = '0;
      for (int k = 1; k < STAGES; k++) res_d[k] = '0;
    end else if (!stall) begin
      // Stage 1: capture a new operation or insert a zeroed bubble.
      vld_d[0] = accept;
      en_d[0]  = accept & rd_en;
      rd_d[0]  = accept ? rd_addr : 5'd0;
      a1_d     = accept ? a_ext : '0;
      b1_d     = accept ? b_ext : '0;
      f1_d     = accept ? funct : 2'b00;
      // Stage 2: product half selected from stage 1.
      vld_d[1] = vld_q[0];
      en_d[1]  = en_q[0];
      rd_d[1]  = vld_q[0] ? rd_q[0] : 5'd0;
      res_d[1] = vld_q[0] ? sel_res : '0;
      // Stages 3..STAGES: carry the result forward, zeroing bubbles.
      for (int k = 2; k < STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
        en_d[k]  = en_q[k-1];
        rd_d[k]  = vld_q[k-1] ? rd_q[k-1] : 5'd0;
        res_d[k] = vld_q[k-1] ? res_q[k-1] : '0;
      end
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      en_q  <= '0;
      a1_q  <= '0;
      b1_q  <= '0;
      f1_q  <= '0;
      for (int k = 0; k < STAGES; k++) rd_q[k] <= '0;
      for (int k = 1; k < STAGES; k++) res_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      en_q  <= en_d;
      a1_q  <= a1_d;
      b1_q  <= b1_d;
      f1_q  <= f1_d;
      rd_q  <= rd_d;
      res_q <= res_d;
    end
  end

  assign out_valid   = vld_q[LAST];
  assign out_rd_en   = en_q[LAST];
  assign out_rd_addr = rd_q[LAST];
  assign ans         = res_q[LAST];
  assign busy        = |vld_q;

`ifdef MULTIPLIER_STAGE_TAP_EN
  // Pack per-stage destinations for the hazard unit; stage 1 in bits [4:0].
  always_comb begin
    stage_rd_addr = '0;
    for (int k = 0; k < STAGES; k++) stage_rd_addr[5*k +: 5] = rd_q[k];
  end
  assign stage_rd_en = en_q;
`else
  assign stage_rd_addr = '0;
  assign stage_rd_en   = '0;
`endif

endmodule

// File: doc/multiplier_unit.md
MULTIPLIER_UNIT -- requirements
Module: multiplier_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- XLEN, 32, operand and result width; legal values 8..64.
- STAGES, 3, register depth from operand capture to result; legal values 2..8.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the only clock; all state changes on its rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- stall, in, 1, freezes the whole pipeline.
- flush, in, 1, kills all in-flight operations.
- in_valid, in, 1, an operation is presented.
- rs1_value, in, XLEN, multiplicand.
- rs2_value, in, XLEN, multiplier.
- funct, in, 2, operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- rd_addr, in, 5, destination register.
- rd_en, in, 1, the operation writes rd.
- out_valid, out, 1, ans/out_rd_* hold a completed operation.
- out_rd_addr, out, 5, destination of the completed operation.
- out_rd_en, out, 1, out_valid & the captured rd_en.
- ans, out, XLEN, result.
- busy, out, 1, OR of valid bits over all STAGES registers.
- stage_rd_addr, out, 5*STAGES, per-stage rd_addr; stage 1 in bits [4:0].
- stage_rd_en, out, STAGES, per-stage valid & rd_en; stage 1 in bit 0.

Function
REQ-003 An operation SHALL be accepted at a rising edge where in_valid=1, stall=0, flush=0.
REQ-004 An accepted operation SHALL appear with out_valid=1 after exactly STAGES un-stalled rising edges, counting the accepting edge as edge 1.
REQ-005 A rising edge with stall=0 and no accepted operation SHALL insert a bubble (valid=0) into stage 1.
REQ-006 While stall=1 and flush=0, every register, including all outputs, SHALL hold its value.
REQ-007 flush=1 SHALL clear every stage valid bit and out_valid at that edge, regardless of stall; an in_valid presented in the same cycle SHALL be dropped.
REQ-008 Operand rs1 SHALL be extended to XLEN+1 bits: sign-extended for MULH and MULHSU, zero-extended otherwise.
REQ-009 Operand rs2 SHALL be extended to XLEN+1 bits: sign-extended for MULH only, zero-extended otherwise.
REQ-010 The signed product SHALL be 2*XLEN+2 bits wide; ans SHALL be bits [XLEN-1:0] for MUL and bits [2*XLEN-1:XLEN] for the other three operations.
REQ-011 The multiply logic MAY be retimed freely across stages; only REQ-004 latency and REQ-010 results are observable.
REQ-012 When a bubble or a flush enters the output register, ans, out_rd_addr and out_rd_en SHALL load 0.
REQ-013 The stage k fields (rd_addr, rd_en, funct) SHALL advance with the data; stage STAGES is the output register.
REQ-014 Back-to-back accepted operations SHALL sustain a throughput of one per un-stalled cycle, with no inter-operation interference.

Reset
REQ-015 While rst_n=0, all valid bits, out_valid, out_rd_en, busy, stage_rd_en, ans, out_rd_addr and stage_rd_addr SHALL be 0.
REQ-016 An operation in flight when rst_n falls SHALL be discarded and SHALL never appear at the outputs.
REQ-017 The first operation SHALL be accepted no earlier than the first rising edge after rst_n rises.

Configuration
REQ-018 With MULTIPLIER_STAGE_TAP_EN defined, stage_rd_addr and stage_rd_en SHALL reflect the live stage contents for hazard detection.
REQ-019 Without MULTIPLIER_STAGE_TAP_EN, stage_rd_addr and stage_rd_en SHALL be tied to 0 and no tap logic SHALL be synthesised; all other behaviour is unchanged.

Verification
REQ-020 XLEN=32, STAGES=3: MUL 0x80000000 x 0xFFFFFFFF accepted at edge 1 -> out_valid=1 after edge 3, ans=0x80000000.
REQ-021 MULH 0xFFFFFFFF x 0xFFFFFFFF -> ans=0x00000000.
REQ-022 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> ans=0xFFFFFFFE.
REQ-023 MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> ans=0xFFFFFFFF.
REQ-024 MULH 0x80000000 x 0x80000000 -> ans=0x40000000.
REQ-025 Accept ops with rd=5,6,7 on consecutive edges, then stall=1 for 4 cycles -> outputs frozen; on release, results emerge in order rd=5,6,7, one per cycle.
REQ-026 Assert flush with two ops in flight and in_valid=1 -> no out_valid for the next STAGES edges, busy=0 after the flush edge.
REQ-027 Drop rst_n mid-operation -> outputs 0 immediately, without waiting for a clock edge; the flushed op never appears.
